// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Buffered 8N1 UART transmitter. Bytes arrive over a valid/ready handshake
//   into a 2**DEPTH_LOG2 byte FIFO and are serialised LSB first on serial_tx.
//   Back-to-back frames are contiguous: when STOP ends with data queued, the
//   next START begins on the very next cycle.
//
// Ports
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_data    byte to transmit
//   in_valid   in_data is valid this cycle
//   in_ready   FIFO can accept a byte (level not full, registers only)
//   serial_tx  UART line, idle high, registered
//   busy       a frame is in progress (state != IDLE)
//   level      bytes currently held in the FIFO
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  serial_tx,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]       CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0] FULL     = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cyc, cyc_next;
    logic [2:0]            bit_idx, bit_next;
    logic [7:0]            shift, shift_next;
    logic                  tx, tx_next;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  push, pop;
    logic                  has_data;
    logic                  period_end;

    // in_ready depends only on the registered level, so a full FIFO refuses a
    // push even on the edge where a pop frees a slot.
    assign in_ready   = (level != FULL);
    assign push       = in_valid && in_ready;
    assign has_data   = (level != '0);
    assign period_end = (cyc == CYC_LAST);
    assign busy       = (state != IDLE);
    assign serial_tx  = tx;

    // Next-state logic. tx_next is the line value for the state being entered,
    // so the line register changes exactly on the state-entry edge.
    always_comb begin
        state_next = state;
        cyc_next   = cyc;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = tx;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                tx_next  = 1'b1;
                cyc_next = '0;
                if (has_data) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end

            START: begin
                if (period_end) begin
                    cyc_next   = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    tx_next    = shift[0];
                end else begin
                    cyc_next = cyc + 1'b1;
                end
            end

            DATA: begin
                if (period_end) begin
                    cyc_next   = '0;
                    shift_next = shift >> 1;
                    // shift[1] becomes the next bit once the shift lands
                    tx_next    = shift[1];
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end else begin
                    cyc_next = cyc + 1'b1;
                end
            end

            STOP: begin
                if (period_end) begin
                    cyc_next = '0;
                    if (has_data) begin
                        // chain straight into the next frame, no idle cycle
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    cyc_next = cyc + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                cyc_next   = '0;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cyc     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            cyc     <= cyc_next;
            bit_idx <= bit_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    // FIFO bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered
//   Directed bench for uart_tx_buffered with CLKS_PER_BIT=10, DEPTH_LOG2=4.
module tb_uart_tx_buffered;

    logic       clock;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       serial_tx;
    logic       busy;
    logic [4:0] level;

    int total = 0;
    int bad   = 0;

    uart_tx_buffered #(
        .CLKS_PER_BIT(10),
        .DEPTH_LOG2  (4)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .serial_tx(serial_tx),
        .busy     (busy),
        .level    (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called at the first START sample; returns at the last STOP sample.
    task automatic watch_frame(input logic [7:0] b, input string tag);
        logic [9:0] exp_bits;
        logic [9:0] win;
        exp_bits = {1'b1, b, 1'b0};
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < 10; c++) begin
                win[c] = serial_tx;
                if (!(p == 9 && c == 9)) tick();
            end
            check($sformatf("%s_bit%0d", tag, p), {22'd0, win},
                  exp_bits[p] ? 32'h3FF : 32'h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rdy_prev;
        int         idle_bad;
        logic [7:0] fill_bytes;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        check("rst_tx",    {31'd0, serial_tx}, 32'd1);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_level", {27'd0, level},     32'd0);
        check("rst_ready", {31'd0, in_ready},  32'd1);
        reset_n = 1'b1;
        tick();
        tick();

        // single byte 0xAC
        in_valid = 1'b1;
        in_data  = 8'hAC;
        tick();                                   // edge N
        in_valid = 1'b0;
        check("one_lvl_n",  {27'd0, level},     32'd1);
        check("one_tx_n",   {31'd0, serial_tx}, 32'd1);
        tick();                                   // edge N+1
        check("one_busy",   {31'd0, busy},      32'd1);
        check("one_lvl_n1", {27'd0, level},     32'd0);
        watch_frame(8'hAC, "one");
        tick();
        check("one_end_busy", {31'd0, busy},      32'd0);
        check("one_end_lvl",  {27'd0, level},     32'd0);
        check("one_end_tx",   {31'd0, serial_tx}, 32'd1);
        tick();

        // burst of five bytes on consecutive edges
        in_valid = 1'b1;
        in_data  = 8'hAC;
        tick();
        in_data = 8'hAD;
        check("burst_lvl1", {27'd0, level}, 32'd1);
        tick();
        fork
            begin
                in_data = 8'hAE;
                tick();
                in_data = 8'hAF;
                tick();
                in_data = 8'hB0;
                tick();
                in_valid = 1'b0;
                check("burst_peak", {27'd0, level}, 32'd4);
            end
            begin
                watch_frame(8'hAC, "burst0");
                tick(); watch_frame(8'hAD, "burst1");
                tick(); watch_frame(8'hAE, "burst2");
                tick(); watch_frame(8'hAF, "burst3");
                tick(); watch_frame(8'hB0, "burst4");
                tick();
                check("burst_end_busy", {31'd0, busy},  32'd0);
                check("burst_end_lvl",  {27'd0, level}, 32'd0);
            end
        join
        tick();

        // fill with in_valid held high, data 0x00..0x13
        in_valid   = 1'b1;
        in_data    = 8'h00;
        fill_bytes = 8'h00;
        rdy_prev   = in_ready;
        fork
            begin
                int  edge_n;
                bit  done;
                edge_n = 0;
                done   = 1'b0;
                while (!done && edge_n < 400) begin
                    tick();
                    edge_n++;
                    if (in_valid && rdy_prev) begin
                        if (fill_bytes == 8'h13) begin
                            in_valid = 1'b0;
                            done     = 1'b1;
                        end else begin
                            fill_bytes = fill_bytes + 8'd1;
                            in_data    = fill_bytes;
                        end
                    end
                    rdy_prev = in_ready;
                    if (edge_n == 17) begin
                        check("fill_full_lvl",   {27'd0, level},    32'd16);
                        check("fill_full_ready", {31'd0, in_ready}, 32'd0);
                    end
                    if (edge_n == 102) begin
                        check("fill_pop_lvl",   {27'd0, level},    32'd15);
                        check("fill_pop_ready", {31'd0, in_ready}, 32'd1);
                    end
                    if (edge_n == 103) begin
                        check("fill_repush_lvl", {27'd0, level}, 32'd16);
                    end
                end
                check("fill_done", {31'd0, done}, 32'd1);
            end
            begin
                tick();
                tick();
                watch_frame(8'h00, "fill00");
                for (int k = 1; k < 20; k++) begin
                    tick();
                    watch_frame(8'(k), $sformatf("fill%02h", k));
                end
                tick();
                check("fill_end_busy", {31'd0, busy},  32'd0);
                check("fill_end_lvl",  {27'd0, level}, 32'd0);
            end
        join
        tick();

        // reset in the middle of DATA for 0x5A with three bytes queued
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_data = 8'h01;
        tick();
        in_data = 8'h02;
        tick();
        in_data = 8'h03;
        tick();
        in_valid = 1'b0;
        check("mid_lvl", {27'd0, level}, 32'd3);
        for (int i = 0; i < 31; i++) tick();     // inside data bit 2 (a zero)
        check("mid_pre_tx",   {31'd0, serial_tx}, 32'd0);
        check("mid_pre_busy", {31'd0, busy},      32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_tx",    {31'd0, serial_tx}, 32'd1);
        check("mid_rst_lvl",   {27'd0, level},     32'd0);
        check("mid_rst_busy",  {31'd0, busy},      32'd0);
        check("mid_rst_ready", {31'd0, in_ready},  32'd1);
        #1 reset_n = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (serial_tx !== 1'b1 || busy !== 1'b0 || level !== 5'd0) idle_bad++;
        end
        check("post_rst_idle", idle_bad, 32'd0);

        // one push per frame, each coinciding with a pop
        in_valid = 1'b1;
        in_data  = 8'hC3;
        fork
            begin
                tick();
                in_data = 8'h96;
                tick();
                in_valid = 1'b0;
                check("alt_lvl0", {27'd0, level}, 32'd1);
                for (int i = 0; i < 99; i++) tick();
                in_valid = 1'b1;
                in_data  = 8'h0F;
                tick();
                in_valid = 1'b0;
                check("alt_lvl1", {27'd0, level}, 32'd1);
                for (int i = 0; i < 99; i++) tick();
                in_valid = 1'b1;
                in_data  = 8'hF0;
                tick();
                in_valid = 1'b0;
                check("alt_lvl2", {27'd0, level}, 32'd1);
            end
            begin
                tick();
                tick();
                watch_frame(8'hC3, "alt0");
                tick(); watch_frame(8'h96, "alt1");
                tick(); watch_frame(8'h0F, "alt2");
                tick(); watch_frame(8'hF0, "alt3");
                tick();
                check("alt_end_busy", {31'd0, busy},  32'd0);
                check("alt_end_lvl",  {27'd0, level}, 32'd0);
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
